alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter BUS, default 8, the datapath width shared with the ALU.
REQ-002 SHALL have parameter NREG, default 4, the register-file depth; indices are 2 bits wide.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  command request.
REQ-006 in_ready  output  1  sequencer can accept a command.
REQ-007 in_op  input  4  opcode: 0 = LOAD immediate; 1..9 = ALU operations; 10..15 = invalid.
REQ-008 in_dst, in_srca, in_srcb  input  2 each  destination and source register indices.
REQ-009 in_imm  input  BUS  immediate value, used by LOAD only.
REQ-010 alu_a, alu_b  output  BUS each  ALU operands.
REQ-011 alu_op  output  4  ALU opcode.
REQ-012 alu_carry_in  output  1  current carry flag C.
REQ-013 alu_y  input  BUS  ALU result.
REQ-014 alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid  input  1 each  ALU status.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_data  output  BUS  result value.
REQ-018 out_flags  output  4  {error, carry, zero, parity}.

Function
REQ-019 SHALL implement an FSM with states IDLE, EXEC and RESP, and SHALL allow at most one command outstanding.
REQ-020 in_ready SHALL equal 1 only in IDLE; a command is accepted when in_valid and in_ready are both 1, and it is latched into a command register.
REQ-021 In IDLE, an accepted command SHALL move the FSM to EXEC.
REQ-022 In EXEC, alu_a/alu_b SHALL carry regfile[srca]/regfile[srcb] and alu_op the latched opcode; the result SHALL be captured at the end of EXEC and the FSM SHALL move to RESP.
REQ-023 Outside EXEC, alu_a, alu_b and alu_op SHALL be 0.
REQ-024 In RESP, out_valid SHALL be 1, and out_data/out_flags SHALL hold stable until out_ready is 1; then the FSM SHALL return to IDLE.
REQ-025 Accept-to-out_valid latency SHALL be exactly 2 cycles, and accept-to-accept SHALL be at least 3 cycles.
REQ-026 For ALU ops (1..9), out_data SHALL be alu_y, and regfile[dst] SHALL be written with alu_y at the end of EXEC.
REQ-027 For ALU ops, zero/parity SHALL come from alu_zero/alu_parity, and error SHALL be 0.
REQ-028 Flag C SHALL be updated on op 2 (add with carry) and op 4 (increment) from alu_carry_out, and on op 5 (decrement) from alu_borrow; all other ops SHALL leave C unchanged.
REQ-029 out_flags.carry SHALL report C after the update.
REQ-030 LOAD (op 0) SHALL write in_imm to regfile[dst], SHALL set out_data = in_imm with zero/parity computed locally, and SHALL ignore alu_invalid.
REQ-031 Op 10..15, or alu_invalid asserted for ops 1..9, SHALL write no register, leave C unchanged, and return out_data = 0 with error = 1.
REQ-032 When dst equals srca or srcb, sources SHALL be read before the write (old value used).
REQ-033 A command presented while in_ready = 0 SHALL NOT be consumed; the upstream holds it.
REQ-034 Arithmetic SHALL be BUS bits wide with wrap-around; any carry SHALL appear only via C.

Reset
REQ-035 While rst_n = 0 at a clock edge: FSM goes to IDLE, all registers and C are cleared to 0, and out_valid, out_data and out_flags are 0.
REQ-036 Reset asserted during EXEC or RESP SHALL discard the command with no regfile write and no response.
REQ-037 in_ready SHALL be 0 while rst_n = 0, and SHALL be 1 in the first cycle after release.

Structure
REQ-038 Package alu_pkg SHALL hold the opcode constants (LOAD = 0, ADD = 1 .. ROR = 9), the FSM state encoding, and the out_flags bit positions.
REQ-039 The register file SHALL be a sub-module alu_regfile with two combinational read ports, one synchronous write port and synchronous clear.
REQ-040 The ALU SHALL be instantiated outside this block, alongside it.

Verification (BUS = 8)
REQ-041 LOAD r0 = 0xFF, LOAD r1 = 0x01, then ADD_CARRY r2 = r0 + r1 with C = 0 -> out_data 0x00, carry = 1, zero = 1, parity = 0; r2 reads 0x00.
REQ-042 Immediately after REQ-041, ADD_CARRY r3 = r1 + r1 -> 0x03 (C consumed as 1), carry = 0, parity = 0.
REQ-043 op 12 with r0 = 0x55 -> error = 1, out_data 0x00, all registers and C unchanged.
REQ-044 Hold out_ready = 0 for 5 cycles in RESP -> out_valid stays 1, out_data stable, in_ready = 0, and a second in_valid is not consumed until release.
REQ-045 Assert rst_n = 0 during EXEC of ADD r0 = r0 + r1 -> no response, r0 reads 0x00, in_ready = 1 in the first cycle after release.
REQ-046 DEC r1 = r1 with r1 = 0x00 -> out_data 0xFF, carry = 1 (borrow), parity = 0; ROL on 0x81 -> 0x03.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and status-flag definitions for the ALU sequencer
// and its register file.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADC  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INC  = 4'd4,
    OP_DEC  = 4'd5,
    OP_AND  = 4'd6,
    OP_XOR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9
  } alu_op_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // out_flags = {error, carry, zero, parity}
  localparam int FLAG_PAR   = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command request and result response channels of the ALU sequencer.
interface alu_sequencer_if #(
  parameter int BUS = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic [1:0]     in_dst;
  logic [1:0]     in_srca;
  logic [1:0]     in_srcb;
  logic [BUS-1:0] in_imm;
  logic           out_valid;
  logic           out_ready;
  logic [BUS-1:0] out_data;
  logic [3:0]     out_flags;

  modport master (
    output in_valid, in_op, in_dst, in_srca, in_srcb, in_imm, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_srca, in_srcb, in_imm, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// synchronous clear that takes priority over the write.
module alu_regfile #(
  parameter int BUS  = 8,
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [BUS-1:0]          wd,
  input  logic [$clog2(NREG)-1:0] ra,
  input  logic [$clog2(NREG)-1:0] rb,
  output logic [BUS-1:0]          rd_a,
  output logic [BUS-1:0]          rd_b
);
  logic [BUS-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a = mem[ra];
  assign rd_b = mem[rb];
endmodule

// File: rtl/alu_sequencer.sv
// Single-outstanding command sequencer: IDLE accepts, EXEC drives the external
// ALU and commits, RESP holds the result until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BUS  = 8,
  parameter int NREG = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus,
  output logic [BUS-1:0] alu_a,
  output logic [BUS-1:0] alu_b,
  output logic [3:0]     alu_op,
  output logic           alu_carry_in,
  input  logic [BUS-1:0] alu_y,
  input  logic           alu_carry_out,
  input  logic           alu_borrow,
  input  logic           alu_zero,
  input  logic           alu_parity,
  input  logic           alu_invalid
);
  seq_state_e     state;
  logic [3:0]     op_p0;
  logic [1:0]     dst_p0, srca_p0, srcb_p0;
  logic [BUS-1:0] imm_p0;
  logic           c_flag;

  logic [BUS-1:0] rd_a, rd_b;
  logic           in_exec, is_load, is_err, wr_en, c_next;
  logic [BUS-1:0] res_data;
  logic [3:0]     res_flags;

  function automatic logic parity(input logic [BUS-1:0] v);
    return ^v;
  endfunction

  assign in_exec      = (state == ST_EXEC);
  assign bus.in_ready = rst_n && (state == ST_IDLE);
  assign alu_a        = in_exec ? rd_a  : '0;
  assign alu_b        = in_exec ? rd_b  : '0;
  assign alu_op       = in_exec ? op_p0 : 4'd0;
  assign alu_carry_in = c_flag;

  // EXEC: build the response and carry update from the latched command
  always_comb begin
    is_load   = (op_p0 == OP_LOAD);
    is_err    = !is_load && ((op_p0 > OP_LAST) || alu_invalid);
    c_next    = c_flag;
    res_data  = '0;
    res_flags = '0;
    if (is_load) begin
      res_data             = imm_p0;
      res_flags[FLAG_ZERO] = (imm_p0 == '0);
      res_flags[FLAG_PAR]  = parity(imm_p0);
    end else if (is_err) begin
      res_flags[FLAG_ERR] = 1'b1;
    end else begin
      res_data             = alu_y;
      res_flags[FLAG_ZERO] = alu_zero;
      res_flags[FLAG_PAR]  = alu_parity;
      case (op_p0)
        OP_ADC, OP_INC: c_next = alu_carry_out;
        OP_DEC:         c_next = alu_borrow;
        default:        c_next = c_flag;
      endcase
    end
    res_flags[FLAG_CARRY] = c_next;
  end

  assign wr_en = in_exec && !is_err;

  // Reads are combinational from the current contents, so a source equal to
  // dst sees the old value; clear on reset overrides an in-flight write.
  alu_regfile #(.BUS(BUS), .NREG(NREG)) u_regfile (
    .clk  (clk),
    .clr  (!rst_n),
    .we   (wr_en),
    .wa   (dst_p0),
    .wd   (res_data),
    .ra   (srca_p0),
    .rb   (srcb_p0),
    .rd_a (rd_a),
    .rd_b (rd_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_p0         <= '0;
      dst_p0        <= '0;
      srca_p0       <= '0;
      srcb_p0       <= '0;
      imm_p0        <= '0;
      c_flag        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_p0   <= bus.in_op;
            dst_p0  <= bus.in_dst;
            srca_p0 <= bus.in_srca;
            srcb_p0 <= bus.in_srcb;
            imm_p0  <= bus.in_imm;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.out_data  <= res_data;
          bus.out_flags <= res_flags;
          c_flag        <= c_next;
          bus.out_valid <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: external ALU stub, table vectors, hand-written
// backpressure/reset sequences, and random commands against a register model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int BUS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.BUS(BUS)) bus ();

  logic [BUS-1:0] alu_a, alu_b, alu_y;
  logic [3:0]     alu_op;
  logic           alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid;
  logic           force_inv = 1'b0;

  alu_sequencer #(.BUS(BUS), .NREG(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_carry_in  (alu_carry_in),
    .alu_y         (alu_y),
    .alu_carry_out (alu_carry_out),
    .alu_borrow    (alu_borrow),
    .alu_zero      (alu_zero),
    .alu_parity    (alu_parity),
    .alu_invalid   (alu_invalid)
  );

  // ALU semantics, returned as {borrow, carry_out, y}
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [8:0] t;
    logic bo;
    t  = '0;
    bo = 1'b0;
    case (op)
      4'd1: t = {1'b0, a} + {1'b0, b};
      4'd2: t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'd3: t = {1'b0, a} - {1'b0, b};
      4'd4: t = {1'b0, a} + 9'd1;
      4'd5: begin t = {1'b0, a - 8'd1}; bo = (a == 8'd0); end
      4'd6: t = {1'b0, a & b};
      4'd7: t = {1'b0, a ^ b};
      4'd8: t = {1'b0, a[6:0], a[7]};
      4'd9: t = {1'b0, a[0], a[7:1]};
      default: t = '0;
    endcase
    return {bo, t[8], t[7:0]};
  endfunction

  logic [9:0] stub_r;
  always_comb begin
    stub_r        = alu_fn(alu_op, alu_a, alu_b, alu_carry_in);
    alu_y         = stub_r[7:0];
    alu_carry_out = stub_r[8];
    alu_borrow    = stub_r[9];
    alu_zero      = (stub_r[7:0] == 8'd0);
    alu_parity    = ^stub_r[7:0];
    alu_invalid   = (alu_op > 4'd9) || force_inv;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural registers and carry flag
  logic [7:0] mregs [4];
  logic       mc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    mc = 1'b0;
  endtask

  task automatic model_cmd(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                           input logic [1:0] b, input logic [7:0] imm, input logic inv,
                           output logic [7:0] ed, output logic [3:0] ef);
    logic [9:0] r;
    if (op == 4'd0) begin
      mregs[d] = imm;
      ed = imm;
      ef = {1'b0, mc, imm == 8'd0, ^imm};
    end else if (op > 4'd9 || inv) begin
      ed = 8'd0;
      ef = {1'b1, mc, 2'b00};
    end else begin
      r = alu_fn(op, mregs[a], mregs[b], mc);
      if (op == 4'd2 || op == 4'd4) mc = r[8];
      else if (op == 4'd5) mc = r[9];
      mregs[d] = r[7:0];
      ed = r[7:0];
      ef = {1'b0, mc, r[7:0] == 8'd0, ^r[7:0]};
    end
  endtask

  task automatic fatal_stop(input string why);
    failures++;
    checks++;
    $display("FAIL %s: bound expired", why);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "stopping");
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) fatal_stop("accept_wait");
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                         input logic [1:0] b, input logic [7:0] imm, input int hold,
                         output logic [7:0] gd, output logic [3:0] gf);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_dst = d; bus.in_srca = a; bus.in_srcb = b; bus.in_imm = imm;
    wait_ready();
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("exec_out_valid", bus.out_valid, 1'b0);
    chk("exec_in_ready", bus.in_ready, 1'b0);
    chk("exec_alu_op", alu_op, op);
    chk("exec_alu_a", alu_a, mregs[a]);
    chk("exec_alu_b", alu_b, mregs[b]);
    chk("exec_carry_in", alu_carry_in, mc);
    @(negedge clk);
    chk("resp_out_valid", bus.out_valid, 1'b1);
    gd = bus.out_data;
    gf = bus.out_flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_out_data", bus.out_data, gd);
      chk("hold_out_flags", bus.out_flags, gf);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", bus.out_valid, 1'b0);
    chk("idle_in_ready", bus.in_ready, 1'b1);
    chk("idle_alu_a", alu_a, 8'd0);
    chk("idle_alu_op", alu_op, 4'd0);
  endtask

  task automatic cmp_resp(input string name, input logic [7:0] gd, input logic [3:0] gf,
                          input logic [7:0] ed, input logic [3:0] ef);
    chk({name, "_data"}, gd, ed);
    if (ef[FLAG_ERR]) chk({name, "_flags_err"}, gf & 4'hC, ef & 4'hC);
    else              chk({name, "_flags"}, gf, ef);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [1:0] d, a, b;
    logic [7:0] imm;
    logic [7:0] ed;
    logic [3:0] ef;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                              input logic [1:0] b, input logic [7:0] imm,
                              input logic [7:0] ed, input logic [3:0] ef);
    vec_t v;
    v.op = op; v.d = d; v.a = a; v.b = b; v.imm = imm; v.ed = ed; v.ef = ef;
    return v;
  endfunction

  initial begin
    #400000;
    fatal_stop("watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [7:0] gd, md;
    logic [3:0] gf, mf;
    logic [3:0] rop;
    logic [1:0] rd, ra, rb;
    logic [7:0] rimm;
    logic rinv;

    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_dst = '0; bus.in_srca = '0;
    bus.in_srcb = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'd0);
    chk("rst_out_flags", bus.out_flags, 4'd0);
    chk("rst_alu_a", alu_a, 8'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1'b1);

    // Directed vectors: op, dst, srca, srcb, imm, expected data, expected {err,c,z,p}
    tbl.push_back(mk(4'd0,  2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 4'b0000));
    tbl.push_back(mk(4'd0,  2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 4'b0001));
    tbl.push_back(mk(4'd2,  2'd2, 2'd0, 2'd1, 8'h00, 8'h00, 4'b0110));
    tbl.push_back(mk(4'd2,  2'd3, 2'd1, 2'd1, 8'h00, 8'h03, 4'b0000));
    tbl.push_back(mk(4'd6,  2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 4'b0010));
    tbl.push_back(mk(4'd6,  2'd3, 2'd3, 2'd3, 8'h00, 8'h03, 4'b0000));
    tbl.push_back(mk(4'd0,  2'd0, 2'd0, 2'd0, 8'h55, 8'h55, 4'b0000));
    tbl.push_back(mk(4'd0,  2'd2, 2'd0, 2'd0, 8'hFF, 8'hFF, 4'b0000));
    tbl.push_back(mk(4'd4,  2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 4'b0110));
    tbl.push_back(mk(4'd12, 2'd0, 2'd0, 2'd1, 8'h77, 8'h00, 4'b1100));
    tbl.push_back(mk(4'd6,  2'd0, 2'd0, 2'd0, 8'h00, 8'h55, 4'b0100));
    tbl.push_back(mk(4'd6,  2'd1, 2'd1, 2'd1, 8'h00, 8'h01, 4'b0101));
    tbl.push_back(mk(4'd6,  2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 4'b0110));
    tbl.push_back(mk(4'd2,  2'd3, 2'd2, 2'd2, 8'h00, 8'h01, 4'b0001));
    tbl.push_back(mk(4'd0,  2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 4'b0010));
    tbl.push_back(mk(4'd5,  2'd1, 2'd1, 2'd1, 8'h00, 8'hFF, 4'b0100));
    tbl.push_back(mk(4'd6,  2'd1, 2'd1, 2'd1, 8'h00, 8'hFF, 4'b0100));
    tbl.push_back(mk(4'd0,  2'd0, 2'd0, 2'd0, 8'h81, 8'h81, 4'b0100));
    tbl.push_back(mk(4'd8,  2'd0, 2'd0, 2'd0, 8'h00, 8'h03, 4'b0100));
    tbl.push_back(mk(4'd9,  2'd3, 2'd0, 2'd0, 8'h00, 8'h81, 4'b0100));
    tbl.push_back(mk(4'd1,  2'd2, 2'd1, 2'd1, 8'h00, 8'hFE, 4'b0101));

    foreach (tbl[i]) begin
      run_cmd(tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].imm, 0, gd, gf);
      model_cmd(tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].imm, 1'b0, md, mf);
      cmp_resp($sformatf("vec%0d", i), gd, gf, tbl[i].ed, tbl[i].ef);
    end

    // Backpressure: hold the response 5 cycles while a second command waits
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'd7; bus.in_dst = 2'd0; bus.in_srca = 2'd0;
    bus.in_srcb = 2'd2; bus.in_imm = 8'h00;
    wait_ready();
    @(posedge clk);
    #1 bus.in_op = 4'd0; bus.in_dst = 2'd1; bus.in_imm = 8'h5A;
    model_cmd(4'd7, 2'd0, 2'd0, 2'd2, 8'h00, 1'b0, md, mf);
    @(negedge clk);
    @(negedge clk);
    chk("bp_out_valid", bus.out_valid, 1'b1);
    cmp_resp("bp_first", bus.out_data, bus.out_flags, md, mf);
    gd = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_data", bus.out_data, gd);
      chk("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_pending", bus.in_ready, 1'b1);
    chk("bp_gap_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model_cmd(4'd0, 2'd1, 2'd0, 2'd2, 8'h5A, 1'b0, md, mf);
    @(negedge clk);
    chk("bp_second_exec", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("bp_second_valid", bus.out_valid, 1'b1);
    cmp_resp("bp_second", bus.out_data, bus.out_flags, md, mf);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_valid", bus.out_valid, 1'b0);

    // Reset in the middle of EXEC drops the command and clears state
    run_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'h12, 0, gd, gf);
    model_cmd(4'd0, 2'd0, 2'd0, 2'd0, 8'h12, 1'b0, md, mf);
    run_cmd(4'd0, 2'd1, 2'd0, 2'd0, 8'h34, 0, gd, gf);
    model_cmd(4'd0, 2'd1, 2'd0, 2'd0, 8'h34, 1'b0, md, mf);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'd1; bus.in_dst = 2'd0; bus.in_srca = 2'd0; bus.in_srcb = 2'd1;
    wait_ready();
    @(posedge clk);
    #1 bus.in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_data", bus.out_data, 8'd0);
    chk("mid_rst_out_flags", bus.out_flags, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_release_ready", bus.in_ready, 1'b1);
    chk("mid_rst_no_resp", bus.out_valid, 1'b0);
    run_cmd(4'd6, 2'd0, 2'd0, 2'd0, 8'h00, 0, gd, gf);
    cmp_resp("mid_rst_r0", gd, gf, 8'h00, 4'b0010);
    model_cmd(4'd6, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, md, mf);

    // Random commands against the model
    for (int n = 0; n < 250; n++) begin
      rop  = 4'($urandom_range(0, 15));
      rd   = 2'($urandom_range(0, 3));
      ra   = 2'($urandom_range(0, 3));
      rb   = 2'($urandom_range(0, 3));
      rimm = 8'($urandom);
      rinv = ($urandom_range(0, 9) == 0);
      force_inv = rinv;
      run_cmd(rop, rd, ra, rb, rimm, int'($urandom_range(0, 2)), gd, gf);
      force_inv = 1'b0;
      model_cmd(rop, rd, ra, rb, rimm, rinv, md, mf);
      cmp_resp($sformatf("rnd%0d_op%0d", n, rop), gd, gf, md, mf);
    end

    // Final sweep of every register through the ALU path
    for (int r = 0; r < 4; r++) begin
      run_cmd(4'd6, 2'(r), 2'(r), 2'(r), 8'h00, 0, gd, gf);
      model_cmd(4'd6, 2'(r), 2'(r), 2'(r), 8'h00, 1'b0, md, mf);
      cmp_resp($sformatf("final_r%0d", r), gd, gf, md, mf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
